// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants, twiddle table and inverse-NTT state encoding.
// The twiddle table is computed at elaboration as bit-reversed powers of the 512th root 1753.
package dilithium_pkg;

   localparam int unsigned N      = 256;
   localparam int unsigned COEF_W = 23;
   localparam logic [COEF_W-1:0] Q     = 23'd8380417;
   localparam logic [COEF_W-1:0] N_INV = 23'd8347681;
   localparam longint unsigned   ROOT  = 64'd1753;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LAYER,
      S_BFLY,
      S_SCALE_STORE,
      S_DONE
   } intt_state_t;

   typedef logic [N-1:0][COEF_W-1:0] zeta_tab_t;

   function automatic zeta_tab_t gen_zeta_tab();
      zeta_tab_t       tab;
      longint unsigned acc;
      longint unsigned base;
      longint unsigned q64;
      int unsigned     e;
      tab = '0;
      q64 = 64'(Q);
      for (int unsigned k = 0; k < N; k++) begin
         e = 0;
         for (int unsigned b = 0; b < 8; b++) begin
            if (k[b]) e = e | (32'd1 << (7 - b));
         end
         acc  = 64'd1;
         base = ROOT;
         for (int unsigned b = 0; b < 8; b++) begin
            if (e[b]) acc = (acc * base) % q64;
            base = (base * base) % q64;
         end
         tab[k[7:0]] = acc[COEF_W-1:0];
      end
      return tab;
   endfunction

   localparam zeta_tab_t ZETA_TAB = gen_zeta_tab();

   function automatic logic [COEF_W-1:0] zeta_rom(input logic [7:0] idx);
      return ZETA_TAB[idx];
   endfunction

endpackage

// File: rtl/mod_mul_q.sv
// Combinational 23x23 multiply reduced fully mod Q.
// Folds with 2^23 == 2^13 - 1 (mod Q); -hi is added as (Q - hi) to stay unsigned.
module mod_mul_q
   import dilithium_pkg::*;
(
   input  logic [COEF_W-1:0] i_a,
   input  logic [COEF_W-1:0] i_b,
   output logic [COEF_W-1:0] o_p
);

   logic [2*COEF_W-1:0] w_prod;
   logic [36:0]         w_s1;
   logic [27:0]         w_s2;
   logic [24:0]         w_s3;
   logic [24:0]         w_q25;

   assign w_q25  = 25'(Q);
   assign w_prod = {23'd0, i_a} * {23'd0, i_b};

   // Each fold shrinks the high part; after three folds the value is below 3Q.
   assign w_s1 = 37'(w_prod[22:0]) + (37'(w_prod[45:23]) << 13)
               + 37'(Q - w_prod[45:23]);
   assign w_s2 = 28'(w_s1[22:0]) + (28'(w_s1[36:23]) << 13)
               + 28'(Q - {9'd0, w_s1[36:23]});
   assign w_s3 = 25'(w_s2[22:0]) + (25'(w_s2[27:23]) << 13)
               + 25'(Q - {18'd0, w_s2[27:23]});

   always_comb begin
      o_p = w_s3[COEF_W-1:0];
      if (w_s3 >= (w_q25 << 1))
         o_p = COEF_W'(w_s3 - (w_q25 << 1));
      else if (w_s3 >= w_q25)
         o_p = COEF_W'(w_s3 - w_q25);
   end

endmodule

// File: rtl/intt_fsm.sv
// Inverse NTT engine: loads 256 NTT-domain coefficients, runs 8 Gentleman-Sande
// layers in place, then writes each coefficient scaled by 256^-1 mod Q.
module intt_fsm
   import dilithium_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_INTT,
   input  logic [23:0] input_chunk,
   output logic        done_INTT,
   output logic [15:0] A,
   output logic [23:0] D,
   output logic        WEB
);

   intt_state_t       r_state, w_state_nxt;
   logic [7:0]        r_i, w_i_nxt;
   logic [8:0]        r_len, w_len_nxt;
   logic [8:0]        r_start, w_start_nxt;
   logic [7:0]        r_j, w_j_nxt;
   logic [8:0]        r_k, w_k_nxt;
   logic [COEF_W-1:0] r_zeta, w_zeta;
   logic [15:0]       r_a, w_a_nxt;
   logic [23:0]       r_d, w_d_nxt;
   logic              r_web, w_web_nxt;
   logic              r_done, w_done_nxt;
   logic [COEF_W-1:0] r_w [N];

   logic [COEF_W-1:0] w_in, w_in_red, w_op_a, w_op_b;
   logic [COEF_W-1:0] w_sum_red, w_diff_red, w_bfly_prod, w_scale_prod;
   logic [COEF_W:0]   w_sum, w_diff;
   logic [7:0]        w_jl, w_blk_end, w_kidx;
   logic [8:0]        w_start_sum;
   logic              w_first, w_last;
   logic              w_unused_msb;

   assign w_unused_msb = input_chunk[23];
   assign w_in         = input_chunk[COEF_W-1:0];
   assign w_in_red     = (w_in >= Q) ? w_in - Q : w_in;

   assign w_jl       = r_j + r_len[7:0];
   assign w_op_a     = r_w[r_j];
   assign w_op_b     = r_w[w_jl];
   assign w_sum      = {1'b0, w_op_a} + {1'b0, w_op_b};
   assign w_sum_red  = (w_sum >= {1'b0, Q}) ? COEF_W'(w_sum - {1'b0, Q}) : w_sum[COEF_W-1:0];
   assign w_diff     = {1'b0, w_op_a} + {1'b0, Q} - {1'b0, w_op_b};
   assign w_diff_red = (w_diff >= {1'b0, Q}) ? COEF_W'(w_diff - {1'b0, Q}) : w_diff[COEF_W-1:0];

   assign w_blk_end   = r_start[7:0] + r_len[7:0] - 8'd1;
   assign w_first     = (r_j == r_start[7:0]);
   assign w_last      = (r_j == w_blk_end);
   assign w_start_sum = r_start + (r_len << 1);
   assign w_kidx      = 8'(r_k - 9'd1);
   // Twiddle is fetched combinationally on a block's first butterfly and held for the rest.
   assign w_zeta      = w_first ? Q - zeta_rom(w_kidx) : r_zeta;

   mod_mul_q u_bfly_mul (
      .i_a (w_zeta),
      .i_b (w_diff_red),
      .o_p (w_bfly_prod)
   );

   mod_mul_q u_scale_mul (
      .i_a (r_w[r_i]),
      .i_b (N_INV),
      .o_p (w_scale_prod)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_i_nxt     = r_i;
      w_len_nxt   = r_len;
      w_start_nxt = r_start;
      w_j_nxt     = r_j;
      w_k_nxt     = r_k;
      w_a_nxt     = '0;
      w_d_nxt     = '0;
      w_web_nxt   = 1'b1;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start_INTT) begin
               w_state_nxt = S_LOAD;
               w_i_nxt     = '0;
            end
         end
         S_LOAD: begin
            w_i_nxt = r_i + 8'd1;
            if (r_i == 8'd255) begin
               w_state_nxt = S_LAYER;
               w_len_nxt   = 9'd1;
               w_k_nxt     = 9'd256;
            end
         end
         S_LAYER: begin
            if (r_len == 9'd256) begin
               w_state_nxt = S_SCALE_STORE;
               w_i_nxt     = '0;
            end else begin
               w_start_nxt = '0;
               w_j_nxt     = '0;
               w_state_nxt = S_BFLY;
            end
         end
         S_BFLY: begin
            if (w_first) w_k_nxt = r_k - 9'd1;
            if (w_last) begin
               if (w_start_sum == 9'd256) begin
                  w_len_nxt   = r_len << 1;
                  w_start_nxt = '0;
                  w_j_nxt     = '0;
                  w_state_nxt = S_LAYER;
               end else begin
                  w_start_nxt = w_start_sum;
                  w_j_nxt     = w_start_sum[7:0];
               end
            end else begin
               w_j_nxt = r_j + 8'd1;
            end
         end
         S_SCALE_STORE: begin
            w_a_nxt   = {8'd0, r_i};
            w_d_nxt   = {1'b0, w_scale_prod};
            w_web_nxt = 1'b0;
            w_i_nxt   = r_i + 8'd1;
            if (r_i == 8'd255) w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_len   <= '0;
         r_start <= '0;
         r_j     <= '0;
         r_k     <= '0;
         r_zeta  <= '0;
         r_a     <= '0;
         r_d     <= '0;
         r_web   <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_i     <= w_i_nxt;
         r_len   <= w_len_nxt;
         r_start <= w_start_nxt;
         r_j     <= w_j_nxt;
         r_k     <= w_k_nxt;
         r_zeta  <= w_zeta;
         r_a     <= w_a_nxt;
         r_d     <= w_d_nxt;
         r_web   <= w_web_nxt;
         r_done  <= w_done_nxt;
      end
   end

   // Coefficient storage is intentionally not cleared by reset.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         if (r_state == S_LOAD) begin
            r_w[r_i] <= w_in_red;
         end else if (r_state == S_BFLY) begin
            r_w[r_j]  <= w_sum_red;
            r_w[w_jl] <= w_bfly_prod;
         end
      end
   end

   assign A         = r_a;
   assign D         = r_d;
   assign WEB       = r_web;
   assign done_INTT = r_done;

endmodule

// File: tb/tb_intt_fsm.sv
// Scoreboard bench for intt_fsm: expected writes are queued per job and a monitor
// compares every WEB=0 cycle; random jobs go through a forward NTT model first.
module tb_intt_fsm;

   localparam longint unsigned Q       = 64'd8380417;
   localparam int unsigned     LATENCY = 1546;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_INTT;
   logic [23:0] input_chunk;
   logic        done_INTT;
   logic [15:0] A;
   logic [23:0] D;
   logic        WEB;

   typedef struct {
      logic [15:0] a;
      logic [23:0] d;
   } wr_t;

   wr_t             exp_q[$];
   int unsigned     checks = 0;
   int unsigned     failures = 0;
   int unsigned     done_pending = 0;
   int unsigned     dones_seen = 0;
   int unsigned     cyc = 0;
   int unsigned     t_start = 0;
   bit              mon_en = 1'b0;
   logic [23:0]     stim [256];
   longint unsigned poly [256];
   longint unsigned hat  [256];

   intt_fsm dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_INTT  (start_INTT),
      .input_chunk (input_chunk),
      .done_INTT   (done_INTT),
      .A           (A),
      .D           (D),
      .WEB         (WEB)
   );

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int unsigned brv8(input int unsigned x);
      int unsigned r;
      r = 0;
      for (int b = 0; b < 8; b++) if (x[b]) r = r | (32'd1 << (7 - b));
      return r;
   endfunction

   function automatic longint unsigned powmod(input longint unsigned b, input int unsigned e);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < e; i++) r = (r * b) % Q;
      return r;
   endfunction

   // Cooley-Tukey forward NTT of poly into hat, plain-domain twiddles 1753^brv(k).
   task automatic fwd_ntt();
      longint unsigned z, t;
      int unsigned     k, len, st;
      for (int i = 0; i < 256; i++) hat[i] = poly[i];
      k = 0;
      len = 128;
      while (len > 0) begin
         st = 0;
         while (st < 256) begin
            k++;
            z = powmod(64'd1753, brv8(k));
            for (int unsigned j = st; j < st + len; j++) begin
               t = (z * hat[j + len]) % Q;
               hat[j + len] = (hat[j] + Q - t) % Q;
               hat[j] = (hat[j] + t) % Q;
            end
            st = st + 2 * len;
         end
         len = len >> 1;
      end
   endtask

   task automatic check_eq(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic prep_random();
      longint unsigned h;
      for (int i = 0; i < 256; i++) poly[i] = longint'($urandom_range(8380416, 0));
      fwd_ntt();
      for (int i = 0; i < 256; i++) begin
         h = hat[i];
         if (h < 8191 && $urandom_range(1, 0) == 1) h = h + Q;
         stim[i] = {1'($urandom_range(1, 0)), 23'(h)};
      end
   endtask

   task automatic prep_const(input logic [23:0] in_val, input longint unsigned out0);
      for (int i = 0; i < 256; i++) begin
         stim[i] = in_val;
         poly[i] = (i == 0) ? out0 : 0;
      end
   endtask

   task automatic load_stream();
      @(negedge clk);
      start_INTT = 1'b1;
      @(posedge clk);
      #1 t_start = cyc;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         start_INTT  = 1'b0;
         input_chunk = stim[i];
      end
      @(negedge clk);
      input_chunk = '0;
   endtask

   task automatic run_job(input int unsigned extra_start_at);
      int unsigned base;
      wr_t         w;
      for (int i = 0; i < 256; i++) begin
         w.a = 16'(i);
         w.d = {1'b0, poly[i][22:0]};
         exp_q.push_back(w);
      end
      done_pending++;
      base = dones_seen;
      load_stream();
      for (int unsigned n = 0; n < 3000 && dones_seen == base; n++) begin
         @(negedge clk);
         start_INTT = (n == extra_start_at);
      end
      start_INTT = 1'b0;
      checks++;
      if (dones_seen == base) begin
         failures++;
         $display("FAIL job_timeout: got no done_INTT, expected one within 3000 cycles");
         exp_q.delete();
         done_pending = 0;
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      start_INTT  = 1'b0;
      input_chunk = '0;

      fork
         begin : monitor
            wr_t e;
            forever begin
               @(negedge clk);
               if (mon_en) begin
                  if (WEB == 1'b0) begin
                     if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL stray_write: got write A=%0d D=%0d, expected no write", A, D);
                     end else begin
                        e = exp_q.pop_front();
                        check_eq($sformatf("write_A[%0d]", e.a), A, e.a);
                        check_eq($sformatf("write_D[%0d]", e.a), D, e.d);
                     end
                  end
                  if (done_INTT) begin
                     if (done_pending == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL stray_done: got done_INTT=1, expected 0");
                     end else begin
                        done_pending--;
                        check_eq("writes_left_at_done", exp_q.size(), 0);
                        check_eq("latency", cyc - t_start, LATENCY);
                        check_eq("web_at_done", WEB, 1);
                     end
                     dones_seen++;
                  end
               end
            end
         end
      join_none

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("reset_WEB", WEB, 1);
      check_eq("reset_A", A, 0);
      check_eq("reset_D", D, 0);
      check_eq("reset_done", done_INTT, 0);
      rst_n  = 1'b1;
      mon_en = 1'b1;
      repeat (20) @(negedge clk);

      prep_const(24'd1, 1);
      run_job(9999);
      prep_const(24'd5, 5);
      run_job(9999);
      prep_const(24'd0, 0);
      run_job(9999);

      // Q+3 everywhere, bit 23 toggled on odd indices: must behave as constant 3.
      prep_const(24'(Q + 3), 3);
      for (int i = 1; i < 256; i += 2) stim[i] = stim[i] | 24'h800000;
      run_job(9999);

      for (int r = 0; r < 3; r++) begin
         prep_random();
         run_job(9999);
      end

      prep_random();
      run_job(100);

      // Reset in the middle of the butterfly phase, then a clean job.
      prep_random();
      load_stream();
      repeat (300) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("abort_WEB", WEB, 1);
      check_eq("abort_done", done_INTT, 0);
      check_eq("abort_A", A, 0);
      rst_n = 1'b1;
      repeat (1600) @(negedge clk);

      prep_random();
      run_job(9999);

      repeat (5) @(negedge clk);
      check_eq("queue_empty_at_end", exp_q.size(), 0);
      check_eq("done_count", dones_seen, 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
